// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: combinational instruction-memory port plus the decode handoff.
// Handshake: out_valid/out_instr/out_pc are stable while out_valid is high; a word
// transfers on any rising edge where out_valid && out_ready. Valid never waits on ready.
interface fetch_ctrl_if #(
  parameter int ADDRESS_LEN = 32,
  parameter int DATA_LEN    = 32
);
  logic [ADDRESS_LEN-1:0] imem_addr;
  logic [DATA_LEN-1:0]    imem_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_LEN-1:0]    out_instr;
  logic [ADDRESS_LEN-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, buffers fetched words in a small FIFO,
// and handles redirect/flush, freeze and halt-on-self-branch.
module fetch_ctrl #(
  parameter int                     ADDRESS_LEN = 32,
  parameter int                     DATA_LEN    = 32,
  parameter int                     FIFO_DEPTH  = 2,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  fetch_ctrl_if.master           bus,
  output logic                   halted,
  output logic [31:0]            fetch_count,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       occ_q, occ_d;
  logic [31:0]            fetch_count_q, fetch_count_d;

  logic [DATA_LEN-1:0]    instr_mem_q [FIFO_DEPTH];
  logic [ADDRESS_LEN-1:0] npc_mem_q   [FIFO_DEPTH];

  logic                   fifo_full;
  logic                   pop;
  logic                   fire;
  logic                   self_branch;
  logic [ADDRESS_LEN-1:0] pc_plus4;
  logic                   unused_addr_bits;

  // Redirect targets are word aligned; the low address bits are ignored.
  assign unused_addr_bits = ^branch_addr[1:0];

  assign pc_plus4    = pc_q + ADDRESS_LEN'(4);
  assign fifo_full   = (occ_q == CNT_W'(FIFO_DEPTH));
  assign pop         = bus.out_valid && bus.out_ready;
  assign fire        = (state_q == S_RUN) && !freeze && !branch_taken && (!fifo_full || pop);
  assign self_branch = (bus.imem_data[27:24] == 4'b1010) && (bus.imem_data[23:0] == 24'hFFFFFF);

  always_comb begin
    state_d = state_q;
    if (branch_taken && (state_q != S_INIT)) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_INIT: state_d = S_RUN;
        S_RUN: begin
          if (freeze)                    state_d = S_HOLD;
          else if (fire && self_branch)  state_d = S_HALT;
        end
        S_HOLD: if (!freeze) state_d = S_RUN;
        S_HALT: state_d = S_HALT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // A redirect flushes the buffer and overrides any coincident push or pop.
  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken) begin
      pc_d     = {branch_addr[ADDRESS_LEN-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (fire) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({fire, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Storage needs no reset: entries are only visible while the occupancy covers them.
  always_ff @(posedge clk) begin
    if (fire && !rst) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_data;
      npc_mem_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc    = bus.out_valid ? npc_mem_q[rd_ptr_q]   : '0;
  assign halted        = (state_q == S_HALT);
  assign fetch_count   = fetch_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed test-plan phases then random traffic, checked by a
// rule-level reference model feeding a scoreboard queue drained by an output monitor.
module tb_fetch_ctrl;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'd0;
  localparam int M_INIT = 0, M_RUN = 1, M_HOLD = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;
  logic        self_en = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  int          occ = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_cnt = '0;
  int          mode = M_INIT;
  logic [63:0] e;

  fetch_ctrl_if #(.ADDRESS_LEN(32), .DATA_LEN(32)) bus ();

  fetch_ctrl #(
    .ADDRESS_LEN(32), .DATA_LEN(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .bus(bus), .halted(halted),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory returns the address as data, except an optional self-branch at 184.
  always_comb begin
    if (self_en && bus.imem_addr == 32'd184) bus.imem_data = 32'hEAFF_FFFF;
    else                                     bus.imem_data = bus.imem_addr;
  end

  function automatic logic [31:0] mem_model(logic [31:0] a, logic en);
    if (en && a == 32'd184) return 32'hEAFF_FFFF;
    return a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: applies the fetch rules once per rising edge.
  always @(posedge clk) begin
    logic [31:0] w;
    bit          pop_m, fire_m;
    w = '0;
    if (rst) begin
      m_pc = RPC; occ = 0; exp_q.delete(); mode = M_INIT; m_cnt = '0;
    end else if (branch_taken) begin
      m_pc = branch_addr & 32'hFFFF_FFFC; occ = 0; exp_q.delete(); mode = M_RUN;
    end else begin
      pop_m  = (occ > 0) && bus.out_ready;
      fire_m = (mode == M_RUN) && !freeze && ((occ < DEPTH) || pop_m);
      if (fire_m) begin
        w = mem_model(m_pc, self_en);
        exp_q.push_back({w, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      occ = occ + int'(fire_m) - int'(pop_m);
      if (fire_m && w[27:0] == 28'hAFF_FFFF)   mode = M_HALT;
      else if (mode == M_INIT)                mode = M_RUN;
      else if (mode == M_RUN && freeze)       mode = M_HOLD;
      else if (mode == M_HOLD && !freeze)     mode = M_RUN;
    end
  end

  // Monitor: compares visible state every cycle and drains the scoreboard on each transfer.
  always @(negedge clk) begin
    #2;
    chk("out_valid", 32'(bus.out_valid), 32'(occ > 0));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("fetch_count", fetch_count, m_cnt);
    chk("halted", 32'(halted), 32'(mode == M_HALT));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: out_pc=0x%08h delivered, expected no entry at %0t", bus.out_pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", bus.out_instr, e[63:32]);
        chk("out_pc", bus.out_pc, e[31:0]);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    // Reset released after edge 0, decode always ready
    cyc(1);
    rst = 1'b0;
    #1;
    chk("reset_out_instr", bus.out_instr, 32'd0);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    cyc(6);

    // Decode stalled: buffer fills with 4 and 8, then drains without gaps
    rst = 1'b1; cyc(1);
    rst = 1'b0; bus.out_ready = 1'b0; cyc(5);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_fetch_count", fetch_count, 32'd2);
    chk("stall_imem_addr", bus.imem_addr, 32'd8);
    cyc(4);

    // Redirect from a full buffer to an unaligned target
    bus.out_ready = 1'b0; cyc(4);
    branch_taken = 1'b1; branch_addr = 32'h73; cyc(1);
    branch_taken = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("redirect_imem_addr", bus.imem_addr, 32'h70);
    chk("redirect_flush", 32'(bus.out_valid), 32'd0);
    cyc(3);

    // Freeze for three cycles while decode drains
    freeze = 1'b1; cyc(3);
    freeze = 1'b0; cyc(4);

    // Self-branch at 184 halts fetch; a redirect to 0 restarts it
    self_en = 1'b1;
    branch_taken = 1'b1; branch_addr = 32'd160; cyc(1);
    branch_taken = 1'b0; cyc(12);
    #1;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_imem_addr", bus.imem_addr, 32'd188);
    cyc(1);
    branch_taken = 1'b1; branch_addr = 32'd0; cyc(1);
    branch_taken = 1'b0;
    #1;
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_imem_addr", bus.imem_addr, 32'd0);
    cyc(5);

    // Reset in the middle of a run with entries queued
    self_en = 1'b0;
    rst = 1'b1; cyc(1);
    rst = 1'b0; bus.out_ready = 1'b1; cyc(8);
    bus.out_ready = 1'b0; cyc(4);
    rst = 1'b1; cyc(1);
    rst = 1'b0;
    #1;
    chk("midreset_fetch_count", fetch_count, 32'd0);
    chk("midreset_imem_addr", bus.imem_addr, RPC);
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    cyc(2);

    // Random traffic, including redirects near the top of the address space
    self_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) < 1);
      freeze        = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 6);
      branch_addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 99) < 60);
      cyc(1);
    end
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational instruction memory. Owns the PC and drives the memory address. Captures fetched words into a small FIFO and hands them to decode over a valid/ready handshake. Handles branch redirect/flush, pipeline freeze, and halt-on-self-branch detection.

Parameters:
ADDRESS_LEN, 32, PC / memory address width
DATA_LEN, 32, instruction word width
FIFO_DEPTH, 2, fetch-buffer entries; power of 2, ≥2
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
freeze  in  1  hazard stall; suppresses new fetches only
branch_taken  in  1  redirect request from execute
branch_addr  in  ADDRESS_LEN  redirect target; bits [1:0] treated as 0
imem_addr  out  ADDRESS_LEN  address to instruction memory; equals pc, combinational
imem_data  in  DATA_LEN  word returned combinationally for imem_addr
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head this cycle
out_instr  out  DATA_LEN  head instruction
out_pc  out  ADDRESS_LEN  head fetch address + 4
halted  out  1  self-branch detected; fetching stopped
fetch_count  out  32  number of pushed words; saturates at 0xFFFFFFFF

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; FIFO emptied; state <= S_INIT; halted=0; fetch_count=0.
  - Outputs read out_valid=0, out_instr=0, out_pc=0 in the following cycle.
  - Reset mid-operation discards all FIFO contents.
- FSM states: S_INIT, S_RUN, S_HOLD, S_HALT.
  - S_INIT: one cycle, no fetch; always -> S_RUN.
  - S_RUN: fetch allowed. freeze=1 -> S_HOLD (no fetch that cycle). Push of a self-branch word -> S_HALT.
  - S_HOLD: no fetch. freeze=0 -> S_RUN at the next edge; fetching resumes the cycle after.
  - S_HALT: no fetch; halted=1.
  - branch_taken in any state except S_INIT -> S_RUN.
- Fetch fire:
  - Condition: state=S_RUN && !freeze && !branch_taken && (FIFO not full || pop this cycle).
  - On fire: push {imem_data, pc+4}; pc <= pc+4 (wraps modulo 2^ADDRESS_LEN); fetch_count += 1, saturating.
- Pop: out_valid && out_ready. Simultaneous push and pop when full is allowed; occupancy is unchanged.
- Latency: a word fetched in cycle N is visible at the FIFO head in cycle N+1 at the earliest. No combinational path from imem_data to the out_* ports.
- Self-branch detect: the pushed word has bits[27:24]=4'b1010 and bits[23:0]=24'hFFFFFF (any condition field). The word itself is pushed. halted=1 and fetching stops from the next cycle; pc holds the self-branch address + 4.
- branch_taken (highest priority):
  - At the next edge: FIFO emptied, pc <= {branch_addr[ADDRESS_LEN-1:2], 2'b00}, halted <= 0.
  - No push in the cycle branch_taken is high. A coincident pop is ignored (flush wins). fetch_count is not incremented.
- freeze and branch_taken together: the redirect applies; the state goes to S_RUN, but fetch stays suppressed while freeze remains high.
- Occupancy counter width: clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset released at edge 0, out_ready=1, memory returns address as data: out_valid first high in cycle 2 with out_pc=4; then out_pc=8, 12, 16 on consecutive cycles; fetch_count=3 after cycle 4.
- out_ready=0 after reset: FIFO fills with pc+4=4, 8; imem_addr holds 8; fetch_count=2. Raise out_ready: heads 4, 8, 12 in consecutive cycles with no gap.
- FIFO full, branch_taken=1 with branch_addr=0x73: next cycle out_valid=0 and imem_addr=0x70; following cycle out_pc=0x74.
- freeze=1 for 3 cycles in S_RUN: imem_addr and fetch_count unchanged; FIFO drains via out_ready=1. Fetch resumes one cycle after freeze drops.
- imem_data=0xEAFFFFFF at address 184: that word is delivered with out_pc=188; halted=1 next cycle; imem_addr stays 188 and fetch_count is frozen. branch_taken to 0 -> halted=0, fetch from 0.
- rst=1 mid-run with 2 entries queued and fetch_count=10: next cycle out_valid=0, imem_addr=RESET_PC, fetch_count=0, halted=0.
